control_fsm: RTL and testbench

//  Multi-cycle controller that drives the computation stage and register file for the 16-bit RISC datapath.
//  - Sequences every control line the datapath consumes: register select, load enables, operand selects, shift, ALUop, write-back.
//  - Start handshake: s/w. The instruction is latched at start.
//  - One instruction at a time: decode, read operands, compute, write back, return to wait.

---
 rtl/control_fsm_pkg.sv | 136 +++++++++++++
 rtl/control_fsm_instr_decode.sv | 34 +++
 rtl/control_fsm.sv | 85 ++++++++
 tb/tb_control_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the 16-bit RISC multi-cycle controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Holds the state encodings, instruction field codes, control-line codes and
// the two pure functions (next state, per-state control word) used by the top.
package control_fsm_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   // Instruction classes produced by the decoder
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_MOV_IMM = 3'd1,
      CLS_MOV_REG = 3'd2,
      CLS_ADD     = 3'd3,
      CLS_CMP     = 3'd4,
      CLS_AND     = 3'd5,
      CLS_MVN     = 3'd6
   } iclass_t;

   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_ALU    = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_AND    = 2'b10;
   localparam logic [1:0] ALU_NOTB   = 2'b11;

   localparam logic [2:0] NSEL_NONE  = 3'b000;
   localparam logic [2:0] NSEL_RM    = 3'b001;
   localparam logic [2:0] NSEL_RD    = 3'b010;
   localparam logic [2:0] NSEL_RN    = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b01;

   // Every control line driven towards the datapath, registered as one word
   typedef struct packed {
      logic       w;
      logic       err;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
      logic [1:0] shift;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic state_t next_state(input state_t st, input logic s,
                                         input iclass_t cls);
      state_t nxt;
      nxt = S_WAIT;
      case (st)
         S_WAIT:   nxt = s ? S_DECODE : S_WAIT;
         S_DECODE: begin
            case (cls)
               CLS_MOV_IMM:                   nxt = S_WRITE_IMM;
               CLS_MOV_REG, CLS_MVN:          nxt = S_GET_B;
               CLS_ADD, CLS_CMP, CLS_AND:     nxt = S_GET_A;
               default:                       nxt = S_WAIT;
            endcase
         end
         S_GET_A:  nxt = S_GET_B;
         S_GET_B:  nxt = S_ALU;
         // CMP only updates status, so it skips the register write-back
         S_ALU:    nxt = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
         default:  nxt = S_WAIT;   // WRITE_IMM, WRITE_REG and unused codes
      endcase
      return nxt;
   endfunction

   // Control word for a given state; IR-derived inputs only matter in DECODE/ALU
   function automatic ctrl_t ctrl_for(input state_t st, input iclass_t cls,
                                      input logic legal, input logic [1:0] sh);
      ctrl_t c;
      c = '0;
      case (st)
         S_WAIT:      c.w   = 1'b1;
         S_DECODE:    c.err = ~legal;
         S_WRITE_IMM: begin
            c.nsel  = NSEL_RN;
            c.vsel  = VSEL_IMM;
            c.write = 1'b1;
         end
         S_GET_A: begin
            c.nsel  = NSEL_RN;
            c.loada = 1'b1;
         end
         S_GET_B: begin
            c.nsel  = NSEL_RM;
            c.loadb = 1'b1;
         end
         S_ALU: begin
            c.shift = sh;
            c.bsel  = 1'b0;
            case (cls)
               CLS_ADD: begin c.asel = 1'b1; c.alu_op = ALU_ADD;  c.loadc = 1'b1; end
               CLS_AND: begin c.asel = 1'b1; c.alu_op = ALU_AND;  c.loadc = 1'b1; end
               CLS_CMP: begin c.asel = 1'b1; c.alu_op = ALU_SUB;  c.loads = 1'b1; end
               CLS_MVN: begin c.asel = 1'b0; c.alu_op = ALU_NOTB; c.loadc = 1'b1; end
               // MOV reg passes shifted B through 0 + B
               default: begin c.asel = 1'b0; c.alu_op = ALU_ADD;  c.loadc = 1'b1; end
            endcase
         end
         S_WRITE_REG: begin
            c.nsel  = NSEL_RD;
            c.vsel  = VSEL_C;
            c.write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_fsm_instr_decode.sv
// Instruction classifier: opcode/op -> class, legality, shift field.
// Latency: combinational.
// Backpressure: none.
//
// Ports: opcode[2:0], op[1:0], sh[1:0] in; cls, legal, shift_field out.
module instr_decode
   import control_fsm_pkg::*;
(
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [1:0] sh,
   output iclass_t    cls,
   output logic       legal,
   output logic [1:0] shift_field
);

   always_comb begin
      cls         = CLS_ILLEGAL;
      shift_field = sh;
      if (opcode == OPC_MOV) begin
         if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
         else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end else if (opcode == OPC_ALU) begin
         case (op)
            OP_ADD:  cls = CLS_ADD;
            OP_CMP:  cls = CLS_CMP;
            OP_AND:  cls = CLS_AND;
            default: cls = CLS_MVN;
         endcase
      end
      legal = (cls != CLS_ILLEGAL);
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle controller sequencing register file and ALU stage of the RISC datapath.
// Latency: DECODE one cycle after s is accepted; w returns 2..6 cycles later by class.
// Backpressure: s only sampled in WAIT (w=1); held-high s chains instructions back to back.
//
// Ports: clk, reset (sync, active high), s, instruction[15:0] in;
//        w, err, nsel[2:0], vsel[1:0], write, loada, loadb, asel, bsel,
//        loadc, loads, shift[1:0], ALUop[1:0] out (all registered).
module control_fsm
   import control_fsm_pkg::*;
#(
   parameter int width      = 16,
   parameter int nsel_width = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s,
   input  logic [width-1:0]      instruction,
   output logic                  w,
   output logic                  err,
   output logic [nsel_width-1:0] nsel,
   output logic [1:0]            vsel,
   output logic                  write,
   output logic                  loada,
   output logic                  loadb,
   output logic                  asel,
   output logic                  bsel,
   output logic                  loadc,
   output logic                  loads,
   output logic [1:0]            shift,
   output logic [1:0]            ALUop
);

   state_t           state;
   logic [width-1:0] ir;
   logic [width-1:0] ir_d;
   iclass_t          cls;
   logic             legal;
   logic [1:0]       sh;
   ctrl_t            ctrl;
   logic             unused_ir_bits;

   // IR only changes on the accepting edge; decoding the would-be IR lets the
   // control word be registered for the state being entered, so outputs are
   // pure flop outputs with no path from s/instruction.
   assign ir_d = (state == S_WAIT && s) ? instruction : ir;

   // Register numbers and imm8 are consumed by the datapath, not here
   assign unused_ir_bits = ^{ir_d[10:5], ir_d[2:0]};

   instr_decode u_instr_decode (
      .opcode      (ir_d[15:13]),
      .op          (ir_d[12:11]),
      .sh          (ir_d[4:3]),
      .cls         (cls),
      .legal       (legal),
      .shift_field (sh)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
         ctrl  <= ctrl_for(S_WAIT, CLS_ILLEGAL, 1'b1, 2'b00);
      end else begin
         state <= next_state(state, s, cls);
         ir    <= ir_d;
         ctrl  <= ctrl_for(next_state(state, s, cls), cls, legal, sh);
      end
   end

   assign w     = ctrl.w;
   assign err   = ctrl.err;
   assign nsel  = ctrl.nsel;
   assign vsel  = ctrl.vsel;
   assign write = ctrl.write;
   assign loada = ctrl.loada;
   assign loadb = ctrl.loadb;
   assign asel  = ctrl.asel;
   assign bsel  = ctrl.bsel;
   assign loadc = ctrl.loadc;
   assign loads = ctrl.loads;
   assign shift = ctrl.shift;
   assign ALUop = ctrl.alu_op;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus pushes the hand-computed control
// word expected on each following cycle; the monitor pops one per cycle and compares.
// Vector layout: {w,err,nsel,vsel,write,loada,loadb,asel,bsel,loadc,loads,shift,ALUop}.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        s;
   logic [15:0] instruction;
   logic        w, err, write, loada, loadb, asel, bsel, loadc, loads;
   logic [2:0]  nsel;
   logic [1:0]  vsel, shift, alu_op;

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_q[$];
   string       tag_q[$];
   logic [17:0] act;

   control_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .s           (s),
      .instruction (instruction),
      .w           (w),
      .err         (err),
      .nsel        (nsel),
      .vsel        (vsel),
      .write       (write),
      .loada       (loada),
      .loadb       (loadb),
      .asel        (asel),
      .bsel        (bsel),
      .loadc       (loadc),
      .loads       (loads),
      .shift       (shift),
      .ALUop       (alu_op)
   );

   always #5 clk = ~clk;

   assign act = {w, err, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, shift, alu_op};

   // Hand-built control words
   localparam logic [17:0] V_WAIT  = 18'b1_0_000_00_0000000_00_00;
   localparam logic [17:0] V_DEC   = 18'b0_0_000_00_0000000_00_00;
   localparam logic [17:0] V_ERR   = 18'b0_1_000_00_0000000_00_00;
   localparam logic [17:0] V_WIMM  = 18'b0_0_100_01_1000000_00_00;
   localparam logic [17:0] V_GETA  = 18'b0_0_100_00_0100000_00_00;
   localparam logic [17:0] V_GETB  = 18'b0_0_001_00_0010000_00_00;
   localparam logic [17:0] V_WREG  = 18'b0_0_010_00_1000000_00_00;
   //                                  w e nsel vs wlLaAbcs sh op
   localparam logic [17:0] V_ADD01 = 18'b0_0_000_00_0001010_01_00; // asel, loadc, LSL1
   localparam logic [17:0] V_CMP   = 18'b0_0_000_00_0001001_00_01; // asel, loads, sub
   localparam logic [17:0] V_AND   = 18'b0_0_000_00_0001010_00_10;
   localparam logic [17:0] V_MOVR  = 18'b0_0_000_00_0000010_11_00; // 0 + B, shift 11
   localparam logic [17:0] V_MVN10 = 18'b0_0_000_00_0000010_10_11;
   localparam logic [17:0] V_MVN01 = 18'b0_0_000_00_0000010_01_11;

   task automatic push(input logic [17:0] v, input string tag);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   // Monitor: one control word per cycle, sampled after the edge settles
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            logic [17:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %b expected %b (w err nsel vsel wr la lb as bs lc ls sh op)",
                        t, act, e);
            end
         end
      end
   end

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: drain timeout, %0d expectations left, required 0", tag, exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   // Pulse s for one cycle with the given instruction
   task automatic start(input logic [15:0] ins);
      @(negedge clk);
      s           = 1'b1;
      instruction = ins;
   endtask

   task automatic release_s();
      @(negedge clk);
      s = 1'b0;
   endtask

   initial begin
      // 1. Reset with s high and a legal ADD presented: nothing may start
      reset       = 1'b1;
      s           = 1'b1;
      instruction = 16'hA000;
      push(V_WAIT, "reset_c1");
      push(V_WAIT, "reset_c2");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      s     = 1'b0;
      push(V_WAIT, "post_reset_idle");
      drain("reset");

      // 2. MOV R3,#-5: DECODE, WRITE_IMM, WAIT
      start(16'b110_10_011_11111011);
      push(V_DEC,  "movi_decode");
      push(V_WIMM, "movi_write");
      push(V_WAIT, "movi_wait");
      release_s();
      drain("movi");

      // 3. ADD R2,R1,R0 LSL1
      start(16'b101_00_001_010_01_000);
      push(V_DEC,   "add_decode");
      push(V_GETA,  "add_get_a");
      push(V_GETB,  "add_get_b");
      push(V_ADD01, "add_alu");
      push(V_WREG,  "add_write");
      push(V_WAIT,  "add_wait");
      release_s();
      drain("add");

      // 4. CMP R1,R0: status only, no write-back
      start(16'b101_01_001_000_00_000);
      push(V_DEC,  "cmp_decode");
      push(V_GETA, "cmp_get_a");
      push(V_GETB, "cmp_get_b");
      push(V_CMP,  "cmp_alu");
      push(V_WAIT, "cmp_wait");
      release_s();
      drain("cmp");

      // 5. Opcode 111 and MOV with op 01: err pulse, straight back to WAIT
      start(16'hE000);
      push(V_ERR,  "ill111_decode");
      push(V_WAIT, "ill111_wait");
      push(V_WAIT, "ill111_idle");
      release_s();
      drain("ill111");
      start(16'b110_01_000_000_00_000);
      push(V_ERR,  "ill_mov01_decode");
      push(V_WAIT, "ill_mov01_wait");
      release_s();
      drain("ill_mov01");

      // MOV R3,R2 ASR (shift 11) and AND
      start(16'b110_00_000_011_11_010);
      push(V_DEC,  "movr_decode");
      push(V_GETB, "movr_get_b");
      push(V_MOVR, "movr_alu");
      push(V_WREG, "movr_write");
      push(V_WAIT, "movr_wait");
      release_s();
      drain("movr");

      start(16'b101_10_010_011_00_001);
      push(V_DEC,  "and_decode");
      push(V_GETA, "and_get_a");
      push(V_GETB, "and_get_b");
      push(V_AND,  "and_alu");
      push(V_WREG, "and_write");
      push(V_WAIT, "and_wait");
      release_s();
      drain("and");

      // 6. Reset while the ADD sits in GET_B: no ALU, no write-back
      start(16'b101_00_001_010_01_000);
      push(V_DEC,  "rst_add_decode");
      push(V_GETA, "rst_add_get_a");
      push(V_GETB, "rst_add_get_b");
      release_s();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      push(V_WAIT, "rst_mid_c1");
      push(V_WAIT, "rst_mid_c2");
      push(V_WAIT, "rst_mid_c3");
      @(negedge clk);
      reset = 1'b0;
      drain("rst_mid");

      // Two MVNs with s held high; the second instruction word is presented
      // while the first is in DECODE and must not disturb its shift field.
      start(16'b101_11_000_001_10_000);
      push(V_DEC,   "mvn1_decode");
      push(V_GETB,  "mvn1_get_b");
      push(V_MVN10, "mvn1_alu");
      push(V_WREG,  "mvn1_write");
      push(V_WAIT,  "mvn1_wait");
      push(V_DEC,   "mvn2_decode");
      push(V_GETB,  "mvn2_get_b");
      push(V_MVN01, "mvn2_alu");
      push(V_WREG,  "mvn2_write");
      push(V_WAIT,  "mvn2_wait");
      push(V_WAIT,  "mvn2_idle");
      @(negedge clk);
      instruction = 16'b101_11_000_010_01_000;
      // second MVN is accepted on the edge ending mvn1_wait; drop s after it
      for (int i = 0; i < 5; i++) @(negedge clk);
      s = 1'b0;
      drain("mvn_pair");

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
